// File: rtl/tthbif_tx_tap_cal.sv
// Tap calibration sequencer for one HBIF TX lane: sweeps 16 flop/comb tap settings with PRBS7,
// then locks the centre of the longest passing window. Sweep = 16*(1+SETTLE+DWELL)+16 cycles.
module tthbif_tx_tap_cal #(
  parameter int SETTLE_CYC = 8,
  parameter int DWELL_CYC  = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cal_start_i,
  input  logic        manual_en_i,
  input  logic [1:0]  manual_comb_i,
  input  logic [1:0]  manual_flop_i,
  input  logic        tx_data_i,
  input  logic        chk_valid_i,
  input  logic        chk_err_i,
  output logic        lane_tx_o,
  output logic [1:0]  comb_tap_sel_o,
  output logic [1:0]  flop_tap_sel_o,
  output logic        cal_busy_o,
  output logic        cal_done_o,
  output logic        cal_fail_o,
  output logic [15:0] pass_map_o
);

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, DWELL, SCAN, DONE, FAIL} state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] DWELL_LAST  = 16'(DWELL_CYC - 1);

  state_t      state, state_nx;
  logic [3:0]  idx, scan_idx, locked, result;
  logic [15:0] cnt;
  logic [6:0]  lfsr;
  logic        err, saw_valid;
  logic [4:0]  run_len, best_len, run_len_nx, best_len_nx;
  logic [3:0]  run_start, best_start, run_start_nx, best_start_nx;
  logic        sweeping, start_ok, sample_err;

  assign sweeping   = (state == APPLY) || (state == SETTLE) || (state == DWELL) || (state == SCAN);
  assign start_ok   = cal_start_i && !manual_en_i &&
                      ((state == IDLE) || (state == DONE) || (state == FAIL));
  assign sample_err = chk_valid_i && chk_err_i;
  assign lane_tx_o  = cal_busy_o ? lfsr[6] : tx_data_i;

  // Longest-run tracker; strict '>' keeps the earliest of equal-length runs.
  always_comb begin
    run_start_nx  = run_start;
    run_len_nx    = run_len;
    best_start_nx = best_start;
    best_len_nx   = best_len;
    if (pass_map_o[scan_idx]) begin
      if (run_len == 5'd0) run_start_nx = scan_idx;
      run_len_nx = run_len + 5'd1;
      if (run_len_nx > best_len) begin
        best_len_nx   = run_len_nx;
        best_start_nx = run_start_nx;
      end
    end else begin
      run_len_nx = 5'd0;
    end
    result = best_start_nx + 4'((best_len_nx - 5'd1) >> 1);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE, FAIL: if (start_ok) state_nx = APPLY;
      APPLY:            state_nx = SETTLE;
      SETTLE:           if (cnt == SETTLE_LAST) state_nx = DWELL;
      DWELL:            if (cnt == DWELL_LAST) state_nx = (idx == 4'd15) ? SCAN : APPLY;
      SCAN:             if (scan_idx == 4'd15) state_nx = (best_len_nx == 5'd0) ? FAIL : DONE;
      default:          state_nx = IDLE;
    endcase
    if (manual_en_i && sweeping) state_nx = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state          <= IDLE;
      idx            <= 4'd0;
      scan_idx       <= 4'd0;
      locked         <= 4'd0;
      cnt            <= 16'd0;
      lfsr           <= 7'h7F;
      err            <= 1'b0;
      saw_valid      <= 1'b0;
      run_len        <= 5'd0;
      best_len       <= 5'd0;
      run_start      <= 4'd0;
      best_start     <= 4'd0;
      comb_tap_sel_o <= 2'd0;
      flop_tap_sel_o <= 2'd0;
      cal_busy_o     <= 1'b0;
      cal_done_o     <= 1'b0;
      cal_fail_o     <= 1'b0;
      pass_map_o     <= 16'd0;
    end else begin
      state <= state_nx;

      if (start_ok) begin
        idx        <= 4'd0;
        pass_map_o <= 16'd0;
        cal_done_o <= 1'b0;
        cal_fail_o <= 1'b0;
        cal_busy_o <= 1'b1;
        lfsr       <= 7'h7F;
        locked     <= 4'd0;
      end else if (cal_busy_o) begin
        lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
      end

      case (state)
        APPLY: begin
          cnt       <= 16'd0;
          err       <= 1'b0;
          saw_valid <= 1'b0;
        end
        SETTLE: cnt <= (cnt == SETTLE_LAST) ? 16'd0 : cnt + 16'd1;
        DWELL: begin
          cnt       <= cnt + 16'd1;
          err       <= err | sample_err;
          saw_valid <= saw_valid | chk_valid_i;
          if (cnt == DWELL_LAST) begin
            pass_map_o[idx] <= !(err || sample_err) && (saw_valid || chk_valid_i);
            idx        <= idx + 4'd1;
            scan_idx   <= 4'd0;
            run_len    <= 5'd0;
            best_len   <= 5'd0;
            run_start  <= 4'd0;
            best_start <= 4'd0;
          end
        end
        SCAN: begin
          scan_idx   <= scan_idx + 4'd1;
          run_len    <= run_len_nx;
          best_len   <= best_len_nx;
          run_start  <= run_start_nx;
          best_start <= best_start_nx;
          if (state_nx == DONE) begin
            cal_busy_o <= 1'b0;
            cal_done_o <= 1'b1;
            locked     <= result;
          end else if (state_nx == FAIL) begin
            cal_busy_o <= 1'b0;
            cal_fail_o <= 1'b1;
            locked     <= 4'd0;
          end
        end
        default: ;
      endcase

      if (manual_en_i && sweeping) cal_busy_o <= 1'b0;

      // Manual override wins over everything, including an in-flight sweep.
      if (manual_en_i) begin
        flop_tap_sel_o <= manual_flop_i;
        comb_tap_sel_o <= manual_comb_i;
      end else begin
        case (state)
          APPLY:      {flop_tap_sel_o, comb_tap_sel_o} <= idx;
          IDLE, DONE: {flop_tap_sel_o, comb_tap_sel_o} <= locked;
          FAIL:       {flop_tap_sel_o, comb_tap_sel_o} <= 4'd0;
          SCAN: begin
            if (state_nx == DONE)      {flop_tap_sel_o, comb_tap_sel_o} <= result;
            else if (state_nx == FAIL) {flop_tap_sel_o, comb_tap_sel_o} <= 4'd0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tthbif_tx_tap_cal.sv
// Bench for tthbif_tx_tap_cal: directed sweeps, scoreboard of expected end-of-sweep results.
module tb_tthbif_tx_tap_cal;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cal_start = 1'b0;
  logic        manual_en = 1'b0;
  logic [1:0]  manual_comb = 2'd0;
  logic [1:0]  manual_flop = 2'd0;
  logic        tx_data = 1'b0;
  logic        chk_valid = 1'b0;
  logic        chk_err = 1'b0;
  logic        lane_tx;
  logic [1:0]  comb_tap, flop_tap;
  logic        cal_busy, cal_done, cal_fail;
  logic [15:0] pass_map;

  tthbif_tx_tap_cal #(.SETTLE_CYC(8), .DWELL_CYC(64)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cal_start_i(cal_start), .manual_en_i(manual_en),
    .manual_comb_i(manual_comb), .manual_flop_i(manual_flop), .tx_data_i(tx_data),
    .chk_valid_i(chk_valid), .chk_err_i(chk_err), .lane_tx_o(lane_tx),
    .comb_tap_sel_o(comb_tap), .flop_tap_sel_o(flop_tap), .cal_busy_o(cal_busy),
    .cal_done_o(cal_done), .cal_fail_o(cal_fail), .pass_map_o(pass_map)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pmap;
    logic [1:0]  flop;
    logic [1:0]  comb;
    logic        done;
    logic        fail;
    int          len;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  bit   prbs_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [15:0] pm, input logic [1:0] fl, input logic [1:0] cb,
                      input logic dn, input logic fa, input int len);
    exp_t e;
    e.pmap = pm; e.flop = fl; e.comb = cb; e.done = dn; e.fail = fa; e.len = len;
    sbq.push_back(e);
  endtask

  // Monitor: counts busy cycles, checks PRBS, and scores each end of sweep.
  logic       busy_q = 1'b0;
  int         busy_cnt = 0;
  logic [6:0] mlfsr = 7'h7F;
  logic       first_bit = 1'b0;

  always @(negedge clk) begin : mon
    int         n;
    logic [6:0] cur;
    exp_t       e;
    if (rst_n) begin
      if (cal_busy) begin
        n   = busy_q ? busy_cnt : 0;
        cur = busy_q ? mlfsr : 7'h7F;
        if (prbs_en && n < 128) begin
          check("prbs_bit", lane_tx, cur[6]);
          if (n == 0) first_bit <= lane_tx;
          if (n == 127) check("prbs_period", lane_tx, first_bit);
        end
        mlfsr    <= {cur[5:0], cur[6] ^ cur[5]};
        busy_cnt <= n + 1;
      end
      if (!cal_busy && busy_q) begin
        if (sbq.size() == 0) begin
          check("sb_nonempty", sbq.size(), 1);
        end else begin
          e = sbq.pop_front();
          check("pass_map", pass_map, e.pmap);
          check("flop_tap", flop_tap, e.flop);
          check("comb_tap", comb_tap, e.comb);
          check("done_flag", cal_done, e.done);
          check("fail_flag", cal_fail, e.fail);
          if (e.len > 0) check("busy_len", busy_cnt, e.len);
        end
      end
    end
    busy_q <= rst_n ? cal_busy : 1'b0;
  end

  // mode 0: errors in every cycle for taps not in pass_mask; mode 1: errors only in SETTLE.
  task automatic run_sweep(input int mode, input logic [15:0] pass_mask, input int abort_t);
    int  idx, pos;
    bit  ended;
    ended = 1'b0;
    @(negedge clk) cal_start = 1'b1;
    @(negedge clk) cal_start = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      if (t == 0) check("start_flags", {cal_busy, cal_done, cal_fail}, 3'b100);
      if (t > 0 && !cal_busy) begin
        ended = 1'b1;
        break;
      end
      idx = t / 73;
      pos = t % 73;
      if (t == abort_t) begin
        manual_en   = 1'b1;
        manual_flop = 2'd2;
        manual_comb = 2'd1;
      end
      chk_valid = 1'b1;
      if (t >= 1168)      chk_err = 1'b0;
      else if (mode == 0) chk_err = !pass_mask[idx];
      else                chk_err = (pos >= 1 && pos <= 8);
      @(negedge clk);
    end
    check("sweep_ends", ended, 1'b1);
    chk_err = 1'b0;
  endtask

  initial begin
    // Reset with tx_data toggling; lane must follow combinationally.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) tx_data = ~tx_data;
      #1 check("rst_lane_tx", lane_tx, tx_data);
    end
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("rst_taps", {flop_tap, comb_tap}, 4'd0);
    check("rst_flags", {cal_busy, cal_done, cal_fail}, 3'b000);
    check("rst_pass_map", pass_map, 16'd0);

    // All-pass sweep with PRBS capture: centre of 0..15 is 7.
    push(16'hFFFF, 2'd1, 2'd3, 1'b1, 1'b0, 1184);
    prbs_en = 1'b1;
    run_sweep(0, 16'hFFFF, -1);
    prbs_en = 1'b0;
    repeat (3) @(negedge clk);

    // Pass on 4..9 and 12..13: longest run 4..9, centre 4 + 5>>1 = 6.
    push(16'h33F0, 2'd1, 2'd2, 1'b1, 1'b0, 1184);
    run_sweep(0, 16'h33F0, -1);
    repeat (3) @(negedge clk);

    // Nothing passes.
    push(16'h0000, 2'd0, 2'd0, 1'b0, 1'b1, 1184);
    run_sweep(0, 16'h0000, -1);
    repeat (3) @(negedge clk);

    // Restart after fail; fail must clear at start.
    push(16'hFFFF, 2'd1, 2'd3, 1'b1, 1'b0, 1184);
    run_sweep(0, 16'hFFFF, -1);
    repeat (3) @(negedge clk);

    // Abort in DWELL of index 5: partial map holds 0..4.
    push(16'h001F, 2'd2, 2'd1, 1'b0, 1'b0, 0);
    run_sweep(0, 16'hFFFF, 5 * 73 + 30);
    tx_data = ~tx_data;
    #1 check("abort_lane_tx", lane_tx, tx_data);
    tx_data = ~tx_data;
    #1 check("abort_lane_tx2", lane_tx, tx_data);
    @(negedge clk) manual_en = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_taps_release", {flop_tap, comb_tap}, 4'd0);
    check("abort_flags", {cal_busy, cal_done, cal_fail}, 3'b000);

    // Errors only while settling must not fail any tap.
    push(16'hFFFF, 2'd1, 2'd3, 1'b1, 1'b0, 1184);
    run_sweep(1, 16'hFFFF, -1);
    repeat (3) @(negedge clk);

    check("sb_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
